// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/loader RAM arbiter.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 15;

  function automatic bit ram_lat_ok(input int lat);
    return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between CPU and loader requests.
// MEM_ARB_RR_EN: ties go to the requester not granted last; otherwise the loader wins ties.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic rr_last,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = cpu_req | ldr_req;
    grant_id    = ldr_req ? REQ_LDR : REQ_CPU;
`ifdef MEM_ARB_RR_EN
    if (cpu_req && ldr_req) begin
      grant_id = ~rr_last;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM between CPU core and program loader, one access in flight at a time.
// Build option MEM_ARB_RR_EN enables round-robin tie-breaking (default: loader-first).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic          clk_qzt,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          cpu_hold,
  output logic          busy
);

  localparam int CW = 4;

  if (!ram_lat_ok(RAM_LAT)) begin : g_bad_lat
    $error("mem_arbiter: RAM_LAT must be within 1..15");
  end

  state_t          state_q, state_d;
  logic            winner_q, winner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic            grant_valid, grant_id, rr_last;

  mem_arb_select u_select (
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .rr_last     (rr_last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef MEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  assign rr_last_d = (state_q == DONE) ? winner_q : rr_last_q;
  assign rr_last   = rr_last_q;

  always_ff @(posedge clk_qzt) begin
    if (reset) rr_last_q <= REQ_CPU;
    else       rr_last_q <= rr_last_d;
  end
`else
  assign rr_last = REQ_CPU;
`endif

  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      state_q     <= IDLE;
      winner_q    <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // WAIT spans RAM_LAT cycles; its last cycle is where ram_rdata for the access is valid.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d  = ACCESS;
          winner_d = grant_id;
          we_d     = (grant_id == REQ_LDR) ? ldr_we    : cpu_we;
          addr_d   = (grant_id == REQ_LDR) ? ldr_addr  : cpu_addr;
          wdata_d  = (grant_id == REQ_LDR) ? ldr_wdata : cpu_wdata;
        end
      end
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = CW'(RAM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (winner_q == REQ_LDR) ldr_rdata_d = ram_rdata;
            else                     cpu_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = (state_q == ACCESS) && we_q;
    cpu_ack   = (state_q == DONE) && (winner_q == REQ_CPU);
    ldr_ack   = (state_q == DONE) && (winner_q == REQ_LDR);
    cpu_rdata = cpu_rdata_q;
    ldr_rdata = ldr_rdata_q;
    cpu_hold  = ldr_req || (busy && (winner_q == REQ_LDR));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RAM_LAT=1 instance plus a RAM_LAT=3 instance.
module tb_mem_arbiter;

  typedef struct {
    logic       id;
    logic       we;
    logic [7:0] data;
  } exp_t;

  logic clk_qzt = 1'b0;
  logic reset;
  logic mem_init;
  int   cyc = 0;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk_qzt = ~clk_qzt;
  always @(posedge clk_qzt) cyc <= cyc + 1;

  logic       cpu_req, cpu_we, cpu_ack, ldr_req, ldr_we, ldr_ack, ram_we, cpu_hold, busy;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ldr_addr, ldr_wdata, ldr_rdata;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic       s_cpu_req, s_cpu_we, s_cpu_ack, s_ldr_req, s_ldr_we, s_ldr_ack, s_ram_we, s_cpu_hold, s_busy;
  logic [7:0] s_cpu_addr, s_cpu_wdata, s_cpu_rdata, s_ldr_addr, s_ldr_wdata, s_ldr_rdata;
  logic [7:0] s_ram_addr, s_ram_wdata, s_ram_rdata, s_d1, s_d2;

  logic [7:0] mem  [256];
  logic [7:0] mem3 [256];
  logic [7:0] model [256];
  logic [7:0] prev_cpu, prev_ldr;
  exp_t       exp_q[$];

  mem_arbiter #(.AW(8), .DW(8), .RAM_LAT(1)) dut (
    .clk_qzt(clk_qzt), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .cpu_hold(cpu_hold), .busy(busy)
  );

  mem_arbiter #(.AW(8), .DW(8), .RAM_LAT(3)) dut3 (
    .clk_qzt(clk_qzt), .reset(reset),
    .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
    .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata),
    .ldr_req(s_ldr_req), .ldr_we(s_ldr_we), .ldr_addr(s_ldr_addr), .ldr_wdata(s_ldr_wdata),
    .ldr_ack(s_ldr_ack), .ldr_rdata(s_ldr_rdata),
    .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_we(s_ram_we), .ram_rdata(s_ram_rdata),
    .cpu_hold(s_cpu_hold), .busy(s_busy)
  );

  function automatic logic [7:0] pat(input logic [7:0] a);
    return (a == 8'h10) ? 8'hC3 : (a ^ 8'h5A);
  endfunction

  // RAM models: one-cycle and three-cycle read latency
  always @(posedge clk_qzt) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk_qzt) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem3[i] <= pat(8'(i));
    else if (s_ram_we) mem3[s_ram_addr] <= s_ram_wdata;
    s_d1        <= mem3[s_ram_addr];
    s_d2        <= s_d1;
    s_ram_rdata <= s_d2;
  end

  function automatic void push_exp(input logic id, input logic we, input logic [7:0] addr,
                                   input logic [7:0] wdata);
    exp_t e;
    e.id = id;
    e.we = we;
    if (we) begin
      model[addr] = wdata;
      e.data = id ? prev_ldr : prev_cpu;
    end else begin
      e.data = model[addr];
      if (id) prev_ldr = e.data;
      else    prev_cpu = e.data;
    end
    exp_q.push_back(e);
  endfunction

  task automatic wait_ack(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_qzt);
      if (cpu_ack || ldr_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_init = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    s_cpu_req = 0; s_cpu_we = 0; s_cpu_addr = 0; s_cpu_wdata = 0;
    s_ldr_req = 0; s_ldr_we = 0; s_ldr_addr = 0; s_ldr_wdata = 0;
    repeat (2) @(negedge clk_qzt);
    reset = 1'b0; mem_init = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = pat(8'(i));
    exp_q.delete();
    prev_cpu = 8'h00; prev_ldr = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    n_asrt++;
    if ({cpu_ack, ldr_ack, cpu_rdata, ldr_rdata, ram_addr, ram_wdata, ram_we, cpu_hold, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b/%b rdata=%h/%h addr=%h wdata=%h we=%b hold=%b busy=%b, required all 0",
               cpu_ack, ldr_ack, cpu_rdata, ldr_rdata, ram_addr, ram_wdata, ram_we, cpu_hold, busy);
    end
    n_asrt++;
    if ({s_cpu_ack, s_ldr_ack, s_cpu_rdata, s_ldr_rdata, s_ram_addr, s_ram_wdata, s_ram_we, s_cpu_hold, s_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_lat3: some output nonzero, required all 0");
    end
  endtask

  task automatic test_cpu_read();
    exp_t e;
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
    push_exp(1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk_qzt);
    n_asrt++;
    if (ram_addr !== 8'h10 || ram_we !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_read_access: addr=%h we=%b busy=%b, required 10/0/1", ram_addr, ram_we, busy);
    end
    @(negedge clk_qzt);
    n_asrt++;
    if (cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL cpu_read_early_ack: ack=%b at n+2, required 0", cpu_ack);
    end
    @(negedge clk_qzt);
    n_asrt++;
    if (cpu_ack !== 1'b1) begin
      n_fail++; $display("FAIL cpu_read_ack: ack=%b at n+3, required 1", cpu_ack);
    end else begin
      e = exp_q.pop_front();
      n_asrt++;
      if (cpu_rdata !== e.data) begin
        n_fail++; $display("FAIL cpu_read_data: rdata=%h, required %h", cpu_rdata, e.data);
      end
    end
    cpu_req = 0;
    @(negedge clk_qzt);
    n_asrt++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cpu_read_after: ack=%b busy=%b, required 0/0", cpu_ack, busy);
    end
  endtask

  task automatic test_ldr_write();
    exp_t e;
    int   we_cnt = 0;
    ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h06; ldr_req = 1;
    push_exp(1'b1, 1'b1, 8'h20, 8'h06);
    #1;
    n_asrt++;
    if (cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL ldr_write_hold_n: hold=%b, required 1", cpu_hold);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_qzt);
      if (ram_we === 1'b1) begin
        we_cnt++;
        n_asrt++;
        if (ram_addr !== 8'h20 || ram_wdata !== 8'h06) begin
          n_fail++; $display("FAIL ldr_write_bus: addr=%h data=%h, required 20/06", ram_addr, ram_wdata);
        end
      end
      n_asrt++;
      if (cpu_hold !== 1'b1 || ldr_ack !== (k == 3)) begin
        n_fail++; $display("FAIL ldr_write_cycle%0d: hold=%b ack=%b, required 1/%b", k, cpu_hold, ldr_ack, (k == 3));
      end
    end
    if (ldr_ack === 1'b1) begin
      e = exp_q.pop_front();
      n_asrt++;
      if (ldr_rdata !== e.data) begin
        n_fail++; $display("FAIL ldr_write_rdata_kept: rdata=%h, required %h", ldr_rdata, e.data);
      end
    end
    ldr_req = 0; ldr_we = 0;
    @(negedge clk_qzt);
    n_asrt++;
    if (we_cnt != 1 || cpu_hold !== 1'b0 || ldr_ack !== 1'b0) begin
      n_fail++; $display("FAIL ldr_write_after: we_cycles=%0d hold=%b ack=%b, required 1/0/0", we_cnt, cpu_hold, ldr_ack);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    bit         got;
    int         t0 = 0;
    logic [7:0] nxt_addr [3];
    nxt_addr[0] = 8'h44; nxt_addr[1] = 8'h44; nxt_addr[2] = 8'h20;
    cpu_we = 1; cpu_addr = 8'h44; cpu_wdata = 8'hA5; cpu_req = 1;
    push_exp(1'b0, 1'b1, 8'h44, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      wait_ack(12, got);
      n_asrt++;
      if (!got || cpu_ack !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ack%0d: no cpu ack within budget", i);
      end else begin
        e = exp_q.pop_front();
        n_asrt++;
        if (cpu_rdata !== e.data || (i > 0 && cyc - t0 != 4)) begin
          n_fail++;
          $display("FAIL b2b_txn%0d: rdata=%h gap=%0d, required %h gap 4", i, cpu_rdata, cyc - t0, e.data);
        end
        t0 = cyc;
      end
      if (i < 2) begin
        cpu_we = 0; cpu_addr = nxt_addr[i + 1];
        push_exp(1'b0, 1'b0, nxt_addr[i + 1], 8'h00);
      end
    end
    cpu_req = 0;
    @(negedge clk_qzt);
  endtask

  task automatic test_tie();
    exp_t e;
    bit   got;
    int   n0, t0;
    do_reset();
    cpu_we = 0; cpu_addr = 8'h30; ldr_we = 0; ldr_addr = 8'h40;
    push_exp(1'b1, 1'b0, 8'h40, 8'h00);
    push_exp(1'b0, 1'b0, 8'h30, 8'h00);
    cpu_req = 1; ldr_req = 1; n0 = cyc;
    wait_ack(12, got);
    n_asrt++;
    if (!got || ldr_ack !== 1'b1 || cyc != n0 + 3) begin
      n_fail++; $display("FAIL tie_first: ldr_ack=%b cpu_ack=%b at n+%0d, required ldr at n+3", ldr_ack, cpu_ack, cyc - n0);
    end else begin
      e = exp_q.pop_front();
      n_asrt++;
      if (ldr_rdata !== e.data) begin
        n_fail++; $display("FAIL tie_ldr_data: rdata=%h, required %h", ldr_rdata, e.data);
      end
    end
    ldr_req = 0; t0 = cyc;
    wait_ack(12, got);
    n_asrt++;
    if (!got || cpu_ack !== 1'b1 || cyc - t0 != 4) begin
      n_fail++; $display("FAIL tie_second: cpu_ack=%b gap=%0d, required 1 gap 4", cpu_ack, cyc - t0);
    end else begin
      e = exp_q.pop_front();
      n_asrt++;
      if (cpu_rdata !== e.data) begin
        n_fail++; $display("FAIL tie_cpu_data: rdata=%h, required %h", cpu_rdata, e.data);
      end
    end
    cpu_req = 0;
    @(negedge clk_qzt);
  endtask

  task automatic test_repeated_tie();
    exp_t e;
    bit   got;
    int   t0 = 0;
    do_reset();
    cpu_we = 0; cpu_addr = 8'h50; ldr_we = 0; ldr_addr = 8'h60;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      push_exp(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0, ((i % 2) == 0) ? 8'h60 : 8'h50, 8'h00);
`else
      push_exp(1'b1, 1'b0, 8'h60, 8'h00);
`endif
    end
    cpu_req = 1; ldr_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(12, got);
      n_asrt++;
      if (!got) begin
        n_fail++; $display("FAIL rep_tie_timeout%0d: no ack within budget", i);
      end else begin
        e = exp_q.pop_front();
        if (ldr_ack !== e.id || (ldr_ack ? ldr_rdata : cpu_rdata) !== e.data || (i > 0 && cyc - t0 != 4)) begin
          n_fail++;
          $display("FAIL rep_tie_grant%0d: ldr_ack=%b rdata=%h gap=%0d, required ldr_ack=%b rdata=%h gap 4",
                   i, ldr_ack, ldr_ack ? ldr_rdata : cpu_rdata, cyc - t0, e.id, e.data);
        end
        t0 = cyc;
      end
    end
    cpu_req = 0; ldr_req = 0;
    @(negedge clk_qzt);
  endtask

  task automatic test_lat3();
    logic [7:0] samp = 8'h00;
    do_reset();
    s_cpu_we = 0; s_cpu_addr = 8'h77; s_cpu_req = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_qzt);
      if (k == 1) begin
        n_asrt++;
        if (s_ram_addr !== 8'h77) begin
          n_fail++; $display("FAIL lat3_addr: ram_addr=%h, required 77", s_ram_addr);
        end
      end
      if (k == 4) samp = s_ram_rdata;
      n_asrt++;
      if (s_cpu_ack !== (k == 5)) begin
        n_fail++; $display("FAIL lat3_ack_n%0d: ack=%b, required %b", k, s_cpu_ack, (k == 5));
      end
    end
    n_asrt++;
    if (s_cpu_rdata !== samp || s_cpu_rdata !== pat(8'h77)) begin
      n_fail++; $display("FAIL lat3_data: rdata=%h sampled=%h, required %h", s_cpu_rdata, samp, pat(8'h77));
    end
    s_cpu_req = 0;
    @(negedge clk_qzt);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   got;
    bit   stray = 1'b0;
    do_reset();
    ldr_we = 0; ldr_addr = 8'h21; ldr_req = 1;
    push_exp(1'b1, 1'b0, 8'h21, 8'h00);
    repeat (2) @(negedge clk_qzt);
    n_asrt++;
    if (busy !== 1'b1 || ram_addr !== 8'h21) begin
      n_fail++; $display("FAIL rstmid_wait: busy=%b addr=%h, required 1/21", busy, ram_addr);
    end
    reset = 1; ldr_req = 0;
    @(negedge clk_qzt);
    n_asrt++;
    if ({cpu_ack, ldr_ack, cpu_rdata, ldr_rdata, ram_addr, ram_wdata, ram_we, cpu_hold, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: ack=%b/%b addr=%h we=%b hold=%b busy=%b rdata=%h, required all 0",
               cpu_ack, ldr_ack, ram_addr, ram_we, cpu_hold, busy, ldr_rdata);
    end
    reset = 0;
    exp_q.delete(); prev_cpu = 8'h00; prev_ldr = 8'h00;
    repeat (4) begin
      @(negedge clk_qzt);
      if (ldr_ack !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_asrt++;
    if (stray) begin
      n_fail++; $display("FAIL rstmid_no_ack: activity after reset, required none");
    end
    cpu_we = 0; cpu_addr = 8'h22; cpu_req = 1;
    push_exp(1'b0, 1'b0, 8'h22, 8'h00);
    wait_ack(12, got);
    n_asrt++;
    if (!got || cpu_ack !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fresh_ack: cpu_ack=%b, required 1", cpu_ack);
    end else begin
      e = exp_q.pop_front();
      n_asrt++;
      if (cpu_rdata !== e.data) begin
        n_fail++; $display("FAIL rstmid_fresh_data: rdata=%h, required %h", cpu_rdata, e.data);
      end
    end
    cpu_req = 0;
    @(negedge clk_qzt);
  endtask

  task automatic test_req_drop();
    exp_t e;
    int   acks = 0;
    int   busy_cyc = 0;
    cpu_we = 0; cpu_addr = 8'h33; cpu_req = 1;
    push_exp(1'b0, 1'b0, 8'h33, 8'h00);
    @(negedge clk_qzt);
    cpu_req = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_qzt);
      if (busy === 1'b1) busy_cyc++;
      if (cpu_ack === 1'b1) begin
        acks++;
        e = exp_q.pop_front();
        n_asrt++;
        if (cpu_rdata !== e.data) begin
          n_fail++; $display("FAIL drop_data: rdata=%h, required %h", cpu_rdata, e.data);
        end
      end
    end
    n_asrt++;
    if (acks != 1 || busy_cyc != 2) begin
      n_fail++; $display("FAIL drop_single: acks=%0d busy_cycles=%0d, required 1/2", acks, busy_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_back_to_back();
    test_tie();
    test_repeated_tie();
    test_lat3();
    test_reset_mid();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
